decoder_4to16_reg: RTL and testbench

Registered 4-to-16 one-hot decoder with active-high enable.
- Decodes 4-bit select A into a 16-bit one-hot word.
- Provides a combinational result and a registered copy with 1-cycle latency.
- Used as an address/row-select decoder; all outputs are zero when disabled.

---
 rtl/decoder_4to16_reg.sv | 62 ++++++
 tb/tb_decoder_4to16_reg.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/decoder_4to16_reg.sv
// rtl/decoder_4to16_reg.sv - registered 4-to-16 one-hot decoder with enable
// Two-level predecoded tree; Y is either a 1-cycle registered copy or the raw decode.
module decoder_4to16_reg #(
   parameter bit OUT_REG = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  A,
   input  logic        EN,
   output logic [15:0] Y_comb,
   output logic [15:0] Y,
   output logic        valid
);

   logic [3:0] grp;

   // Upper select bits pick one group of four outputs; EN gates the whole tree here.
   always_comb begin
      grp = 4'b0000;
      if (EN) begin
         grp[A[3:2]] = 1'b1;
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_sub
      logic [3:0] dec;

      always_comb begin
         dec = 4'b0000;
         if (grp[k]) begin
            dec[A[1:0]] = 1'b1;
         end
      end

      assign Y_comb[4*k +: 4] = dec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
      end else begin
         valid <= EN;
      end
   end

   if (OUT_REG) begin : g_reg
      logic [15:0] y_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            y_q <= 16'h0000;
         end else begin
            y_q <= Y_comb;
         end
      end

      assign Y = y_q;
   end else begin : g_byp
      assign Y = Y_comb;
   end

endmodule

// File: tb/tb_decoder_4to16_reg.sv
// tb/tb_decoder_4to16_reg.sv - self-checking bench for decoder_4to16_reg
// Registered and bypass builds share the same inputs.
module tb_decoder_4to16_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  A = 4'd0;
   logic        EN = 1'b0;
   logic [15:0] y_comb, y, yb_comb, yb;
   logic        valid, vb;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   decoder_4to16_reg #(.OUT_REG(1'b1)) u_dut (
      .clk(clk), .rst(rst), .A(A), .EN(EN),
      .Y_comb(y_comb), .Y(y), .valid(valid)
   );

   decoder_4to16_reg #(.OUT_REG(1'b0)) u_byp (
      .clk(clk), .rst(rst), .A(A), .EN(EN),
      .Y_comb(yb_comb), .Y(yb), .valid(vb)
   );

   typedef struct {
      logic [3:0]  a;
      logic        en;
      logic [15:0] exp;
   } vec_t;

   // Reference: one bit per enabled code, built as a counted search over all indices.
   function automatic logic [15:0] ref_decode(input logic [3:0] a, input logic en);
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         if (en && (int'(a) == i)) r = r | (16'h0001 << i);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_onehot(input string name, input logic [15:0] v, input logic vld);
      vectors++;
      if ($countones(v) > 1 || (vld && $countones(v) != 1) || (!vld && v != 16'h0000)) begin
         miscompares++;
         $display("FAIL %s: Y=%h valid=%b not consistent one-hot", name, v, vld);
      end
   endtask

   // Drive on negedge, check combinational paths, then check registered copy after the edge.
   task automatic step(input string name, input logic [3:0] a, input logic en, input logic [15:0] exp);
      @(negedge clk);
      A  = a;
      EN = en;
      #1;
      chk({name, "_comb"}, y_comb, exp);
      chk({name, "_byp"}, yb, exp);
      @(posedge clk);
      #1;
      chk({name, "_y"}, y, exp);
      chk({name, "_valid"}, {15'd0, valid}, {15'd0, en});
      chk({name, "_bvalid"}, {15'd0, vb}, {15'd0, en});
      chk_onehot({name, "_1hot"}, y, valid);
   endtask

   vec_t tbl[10];

   initial begin
      tbl[0] = '{4'd0,  1'b1, 16'h0001};
      tbl[1] = '{4'd1,  1'b1, 16'h0002};
      tbl[2] = '{4'd10, 1'b1, 16'h0400};
      tbl[3] = '{4'd15, 1'b1, 16'h8000};
      tbl[4] = '{4'd0,  1'b0, 16'h0000};
      tbl[5] = '{4'd1,  1'b0, 16'h0000};
      tbl[6] = '{4'd7,  1'b1, 16'h0080};
      tbl[7] = '{4'd7,  1'b0, 16'h0000};
      tbl[8] = '{4'd7,  1'b1, 16'h0080};
      tbl[9] = '{4'd5,  1'b1, 16'h0020};

      // Reset held with live inputs: outputs stay clear across edges
      A  = 4'd5;
      EN = 1'b1;
      #1;
      chk("rst_comb", y_comb, 16'h0020);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_y", y, 16'h0000);
         chk("rst_valid", {15'd0, valid}, 16'h0000);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_rel_y", y, 16'h0000);
      @(posedge clk);
      #1;
      chk("rst_first_y", y, 16'h0020);
      chk("rst_first_valid", {15'd0, valid}, 16'h0001);

      // Exhaustive sweep
      for (int i = 0; i < 16; i++) begin
         step("sweep", 4'(i), 1'b1, 16'h0001 << i);
      end

      // Boundary and enable-toggle table
      for (int i = 0; i < 10; i++) begin
         step("tbl", tbl[i].a, tbl[i].en, tbl[i].exp);
      end

      // Async reset between edges with Y=8000
      step("pre_arst", 4'd15, 1'b1, 16'h8000);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_y", y, 16'h0000);
      chk("arst_valid", {15'd0, valid}, 16'h0000);
      chk("arst_comb", y_comb, 16'h8000);
      @(negedge clk);
      rst = 1'b0;

      // Bypass build responds without a clock edge
      @(negedge clk);
      #1;
      A  = 4'd3;
      EN = 1'b1;
      #1;
      chk("byp_a3", yb, 16'h0008);

      // Randomized against the reference model
      for (int i = 0; i < 300; i++) begin
         logic [3:0] ra;
         logic       ren;
         ra  = 4'($urandom_range(0, 15));
         ren = ($urandom_range(0, 3) != 0);
         step("rand", ra, ren, ref_decode(ra, ren));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
